// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Shares the single port of a 16x4 register file between two requesters.
//   Round-robin grant, one command in flight. A command is either a write
//   of one register or a read of two registers. All regfile controls are
//   driven from flops; read data is returned to the requester that issued it.
//
// Ports
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   reqN_valid/we/addr1/addr2/wdata   request from requester N (held until ready)
//   reqN_ready              combinational accept strobe (IDLE only, winner only)
//   reqN_rvalid             one-cycle read-data strobe
//   reqN_rdata1/rdata2      read data, held until that requester's next read
//   rf_rr1/rf_rr2/rf_wr/rf_wdata/rf_wenable   regfile controls
//   rf_out1/rf_out2         regfile read outputs (high-Z during write cycles)
module regfile_arbiter #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr1,
  input  logic [AW-1:0] req0_addr2,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          req0_rvalid,
  output logic [DW-1:0] req0_rdata1,
  output logic [DW-1:0] req0_rdata2,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr1,
  input  logic [AW-1:0] req1_addr2,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          req1_rvalid,
  output logic [DW-1:0] req1_rdata1,
  output logic [DW-1:0] req1_rdata2,
  output logic [AW-1:0] rf_rr1,
  output logic [AW-1:0] rf_rr2,
  output logic [AW-1:0] rf_wr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_wenable,
  input  logic [DW-1:0] rf_out1,
  input  logic [DW-1:0] rf_out2
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;         // 0: req0 has priority
  logic          owner_q, owner_d;     // requester of the command in flight
  logic          cmd_we_q, cmd_we_d;
  logic [AW-1:0] rf_rr1_q, rf_rr1_d;
  logic [AW-1:0] rf_rr2_q, rf_rr2_d;
  logic [AW-1:0] rf_wr_q, rf_wr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic          rf_wenable_q, rf_wenable_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_1_q, rdata0_1_d;
  logic [DW-1:0] rdata0_2_q, rdata0_2_d;
  logic [DW-1:0] rdata1_1_q, rdata1_1_d;
  logic [DW-1:0] rdata1_2_q, rdata1_2_d;

  logic          grant0, grant1;
  logic          sel_we;
  logic [AW-1:0] sel_addr1, sel_addr2;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    cmd_we_d     = cmd_we_q;
    rf_rr1_d     = rf_rr1_q;
    rf_rr2_d     = rf_rr2_q;
    rf_wr_d      = rf_wr_q;
    rf_wdata_d   = rf_wdata_q;
    rf_wenable_d = 1'b0;               // write enable is a single-cycle pulse
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata0_1_d   = rdata0_1_q;
    rdata0_2_d   = rdata0_2_q;
    rdata1_1_d   = rdata1_1_q;
    rdata1_2_d   = rdata1_2_q;
    grant0       = 1'b0;
    grant1       = 1'b0;

    // Priority side wins on a tie; a lone requester wins regardless of ptr.
    if (state_q == IDLE) begin
      if (ptr_q == 1'b0) begin
        grant0 = req0_valid;
        grant1 = !req0_valid && req1_valid;
      end else begin
        grant1 = req1_valid;
        grant0 = !req1_valid && req0_valid;
      end
    end

    sel_we    = grant1 ? req1_we    : req0_we;
    sel_addr1 = grant1 ? req1_addr1 : req0_addr1;
    sel_addr2 = grant1 ? req1_addr2 : req0_addr2;
    sel_wdata = grant1 ? req1_wdata : req0_wdata;

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d  = grant1;
          ptr_d    = grant0;           // priority passes to the loser
          cmd_we_d = sel_we;
          if (sel_we) begin
            rf_wr_d      = sel_addr1;
            rf_wdata_d   = sel_wdata;
            rf_wenable_d = 1'b1;
          end else begin
            rf_rr1_d = sel_addr1;
            rf_rr2_d = sel_addr2;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = cmd_we_q ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        // Only reached for reads, so rf_wenable is low and rf_out is driven.
        if (owner_q) begin
          rdata1_1_d = rf_out1;
          rdata1_2_d = rf_out2;
          rvalid1_d  = 1'b1;
        end else begin
          rdata0_1_d = rf_out1;
          rdata0_2_d = rf_out2;
          rvalid0_d  = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      cmd_we_q     <= 1'b0;
      rf_rr1_q     <= '0;
      rf_rr2_q     <= '0;
      rf_wr_q      <= '0;
      rf_wdata_q   <= '0;
      rf_wenable_q <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_1_q   <= '0;
      rdata0_2_q   <= '0;
      rdata1_1_q   <= '0;
      rdata1_2_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cmd_we_q     <= cmd_we_d;
      rf_rr1_q     <= rf_rr1_d;
      rf_rr2_q     <= rf_rr2_d;
      rf_wr_q      <= rf_wr_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_wenable_q <= rf_wenable_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_1_q   <= rdata0_1_d;
      rdata0_2_q   <= rdata0_2_d;
      rdata1_1_q   <= rdata1_1_d;
      rdata1_2_q   <= rdata1_2_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign req0_rvalid = rvalid0_q;
  assign req1_rvalid = rvalid1_q;
  assign req0_rdata1 = rdata0_1_q;
  assign req0_rdata2 = rdata0_2_q;
  assign req1_rdata1 = rdata1_1_q;
  assign req1_rdata2 = rdata1_2_q;
  assign rf_rr1      = rf_rr1_q;
  assign rf_rr2      = rf_rr2_q;
  assign rf_wr       = rf_wr_q;
  assign rf_wdata    = rf_wdata_q;
  assign rf_wenable  = rf_wenable_q;

endmodule
